// File: rtl/match_monitor.sv
// match_monitor: counts rising edges of a detector pulse and raises an alarm
// when THRESH events fall inside one WIN_LEN-cycle observation window.
//
// Ports:
//   clk          single clock, rising edge
//   clr          synchronous active-high reset, highest priority
//   det_in       match pulse from the upstream sequence detector
//   alarm_ack    level-sampled alarm acknowledge
//   match_count  total events since reset, saturating at 2^CNT_W-1
//   win_count    events counted in the current window
//   alarm        high while in ALARM (decode of the state register)
//   mon_state    current state: IDLE=00, ARMED=01, ALARM=10
//
// state | meaning
// IDLE  | no window open, waiting for the first event
// ARMED | window open, timer counting down to its close
// ALARM | THRESH events seen in one window, waiting for alarm_ack
module match_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             det_in,
  input  logic             alarm_ack,
  output logic [CNT_W-1:0] match_count,
  output logic [7:0]       win_count,
  output logic             alarm,
  output logic [1:0]       mon_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    ALARM = 2'b10
  } mon_state_t;

  localparam logic [7:0] WIN_LOAD = 8'(WIN_LEN - 1);
  localparam logic [8:0] THRESH_W = 9'(THRESH);

  mon_state_t       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [7:0]       win_q, win_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic             det_q;
  logic             event_w;
  logic [8:0]       win_inc;

  assign event_w = det_in & ~det_q;
  assign win_inc = {1'b0, win_q} + 9'd1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      timer_q <= '0;
      win_q   <= '0;
      match_q <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      win_q   <= win_d;
      match_q <= match_d;
      det_q   <= det_in;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    win_d   = win_q;
    match_d = match_q;

    // The total count runs independently of the window FSM.
    if (event_w && (match_q != {CNT_W{1'b1}})) begin
      match_d = match_q + 1'b1;
    end

    case (state_q)
      IDLE, ARMED: begin
        if ((state_q == IDLE) || (timer_q == 8'd0)) begin
          // No window open, or the current one just closed: an event this
          // cycle becomes the first event of a fresh window.
          timer_d = '0;
          win_d   = '0;
          state_d = IDLE;
          if (event_w) begin
            win_d = 8'd1;
            if (THRESH == 1) begin
              state_d = ALARM;
            end else begin
              state_d = ARMED;
              timer_d = WIN_LOAD;
            end
          end
        end else begin
          timer_d = timer_q - 8'd1;
          if (event_w) begin
            win_d = win_inc[7:0];
            if (win_inc >= THRESH_W) begin
              state_d = ALARM;
            end
          end
        end
      end
      ALARM: begin
        // win_count stays frozen; an event coinciding with the ack only
        // reaches match_count.
        if (alarm_ack) begin
          state_d = IDLE;
          win_d   = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        win_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  assign match_count = match_q;
  assign win_count   = win_q;
  assign alarm       = (state_q == ALARM);
  assign mon_state   = state_q;

endmodule

// File: tb/tb_match_monitor.sv
// Directed bench for match_monitor: a WIN_LEN=8/THRESH=3 instance for the
// window behaviour, plus CNT_W=2 and THRESH=1 instances sharing a second
// input set for saturation and immediate-alarm behaviour.
module tb_match_monitor;

  logic       clk = 1'b0;
  logic       clr, det_in, alarm_ack;
  logic [7:0] match_count, win_count;
  logic       alarm;
  logic [1:0] mon_state;

  logic       clr2, det2, ack2;
  logic [1:0] mc_b;
  logic [7:0] wc_b;
  logic       al_b;
  logic [1:0] st_b;
  logic [7:0] mc_c, wc_c;
  logic       al_c;
  logic [1:0] st_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  match_monitor #(.CNT_W(8), .WIN_LEN(8), .THRESH(3)) dut (
    .clk(clk), .clr(clr), .det_in(det_in), .alarm_ack(alarm_ack),
    .match_count(match_count), .win_count(win_count),
    .alarm(alarm), .mon_state(mon_state)
  );

  match_monitor #(.CNT_W(2), .WIN_LEN(8), .THRESH(3)) dut_sat (
    .clk(clk), .clr(clr2), .det_in(det2), .alarm_ack(ack2),
    .match_count(mc_b), .win_count(wc_b), .alarm(al_b), .mon_state(st_b)
  );

  match_monitor #(.CNT_W(8), .WIN_LEN(8), .THRESH(1)) dut_t1 (
    .clk(clk), .clr(clr2), .det_in(det2), .alarm_ack(ack2),
    .match_count(mc_c), .win_count(wc_c), .alarm(al_c), .mon_state(st_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs to the main instance, sample 1 time unit
  // after the rising edge.
  task automatic step(input logic d, input logic a, input logic c);
    det_in = d; alarm_ack = a; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic d, input logic a, input logic c);
    det2 = d; ack2 = a; clr2 = c;
    @(posedge clk); #1;
  endtask

  task automatic check_main(input string tag, input logic [1:0] st,
                            input logic [7:0] wc, input logic [7:0] mc,
                            input logic al);
    check({tag, ".state"}, 32'(mon_state), 32'(st));
    check({tag, ".win"},   32'(win_count), 32'(wc));
    check({tag, ".match"}, 32'(match_count), 32'(mc));
    check({tag, ".alarm"}, 32'(alarm), 32'(al));
  endtask

  initial begin
    clr = 1'b1; det_in = 1'b0; alarm_ack = 1'b0;
    clr2 = 1'b1; det2 = 1'b0; ack2 = 1'b0;
    #2;
    // Reset with an event and an ack pending: clr must win.
    step(1'b1, 1'b1, 1'b1);
    check_main("reset", 2'b00, 8'd0, 8'd0, 1'b0);

    // Pulses at cycles 0, 3, 6 -> ALARM.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);                      // cycle 0
    check_main("p0", 2'b01, 8'd1, 8'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);                      // cycle 3
    check_main("p3", 2'b01, 8'd2, 8'd2, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);                      // cycle 6
    check_main("p6_alarm", 2'b10, 8'd3, 8'd3, 1'b0 | 1'b1);

    // Events in ALARM update match_count only.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_main("alarm_evt", 2'b10, 8'd3, 8'd4, 1'b1);

    // Ack together with an event: back to IDLE, event counted, no window.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_main("ack_evt", 2'b00, 8'd0, 8'd5, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_main("ack_after", 2'b00, 8'd0, 8'd5, 1'b0);

    // Pulses at cycles 0, 4, 8: the third lands when the timer is 0.
    step(1'b1, 1'b0, 1'b0);                      // cycle 0
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);                      // cycle 4
    check_main("q4", 2'b01, 8'd2, 8'd7, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);                      // cycle 8
    check_main("q8_newwin", 2'b01, 8'd1, 8'd8, 1'b0);
    // The new window stays open for 7 more cycles and closes on the 8th.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
    check_main("win_last", 2'b01, 8'd1, 8'd8, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_main("win_close", 2'b00, 8'd0, 8'd8, 1'b0);

    // det_in held high across clr release and for 10 cycles: one event.
    step(1'b1, 1'b0, 1'b1);
    check_main("clr_hold", 2'b00, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    check_main("hold8", 2'b01, 8'd1, 8'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_main("hold10", 2'b00, 8'd0, 8'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // clr mid-window discards progress; a later pulse opens a new window.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_main("pre_clr", 2'b01, 8'd2, 8'd3, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_main("clr_armed", 2'b00, 8'd0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_main("post_clr", 2'b01, 8'd1, 8'd1, 1'b0);

    // CNT_W=2 saturation and THRESH=1 immediate alarm.
    step2(1'b0, 1'b0, 1'b1);
    step2(1'b1, 1'b0, 1'b0);
    check("t1.state", 32'(st_c), 32'h2);
    check("t1.win",   32'(wc_c), 32'h1);
    check("t1.alarm", 32'(al_c), 32'h1);
    check("sat.match1", 32'(mc_b), 32'h1);
    step2(1'b0, 1'b0, 1'b0);
    step2(1'b1, 1'b0, 1'b0);
    step2(1'b0, 1'b0, 1'b0);
    step2(1'b1, 1'b0, 1'b0);
    check("sat.match3", 32'(mc_b), 32'h3);
    check("sat.alarm",  32'(al_b), 32'h1);
    step2(1'b0, 1'b0, 1'b0);
    step2(1'b1, 1'b0, 1'b0);
    step2(1'b0, 1'b0, 1'b0);
    step2(1'b1, 1'b0, 1'b0);
    check("sat.match5", 32'(mc_b), 32'h3);
    check("sat.win",    32'(wc_b), 32'h3);
    check("t1.match5",  32'(mc_c), 32'h5);
    check("t1.winfrz",  32'(wc_c), 32'h1);
    step2(1'b0, 1'b1, 1'b0);
    check("t1.ack",     32'(st_c), 32'h0);
    check("t1.ackal",   32'(al_c), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
